sram_sdram_address_gen: RTL and testbench

Parametrised multi-line address generator for the convolution datapath, the next generation of `address_calc`. It produces the SRAM address (row-cache ring of `NUM_LINES` image rows, or output region) and the SDRAM address (source read or destination write) for the memory controllers. It sits between the top-level control FSM and the SRAM/SDRAM controllers. Separate SRAM and SDRAM advance strobes let both memories stream in the same cycle.

---
 rtl/sram_sdram_address_gen.sv | 147 ++++++++++++++
 tb/tb_sram_sdram_address_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sdram_address_gen.sv
// sram_sdram_address_gen
//   Multi-line SRAM/SDRAM address generator for the convolution datapath.
//   SRAM side: a ring of NUM_LINES row-cache lines, or a linear output region.
//   SDRAM side: a source read pointer (stops at finish) or a destination
//   write pointer.
//
// Ports
//   clk, n_rst             clock, synchronous active-low reset
//   start_flag             reload all pointers from the base inputs, enter RUN
//   sram_mode/sdram_mode   select pointer (1 = row cache / read)
//   sram_update            advance the selected SRAM pointer
//   sdram_update           advance the selected SDRAM pointer
//   image_width            pixels per row
//   start/finish/dest_address_sdram, rowCache/output_address_sram  bases
//   sram_address, sdram_address   current addresses (combinational muxes)
//   line_sel               current row-cache line
//   busy, rd_done, addr_err
//
// Optional feature: define ADDR_GEN_ERR_CHECK_EN to enable the sticky
// addr_err protocol checker; otherwise addr_err is tied to 0.
module sram_sdram_address_gen #(
    parameter int ADDR_W    = 26,
    parameter int WIDTH_W   = 13,
    parameter int NUM_LINES = 3,
    parameter int OUT_TRIM  = 1,
    localparam int LS_W     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start_flag,
    input  logic              sram_mode,
    input  logic              sdram_mode,
    input  logic              sram_update,
    input  logic              sdram_update,
    input  logic [WIDTH_W-1:0] image_width,
    input  logic [ADDR_W-1:0] start_address_sdram,
    input  logic [ADDR_W-1:0] finish_address_sdram,
    input  logic [ADDR_W-1:0] dest_address_sdram,
    input  logic [ADDR_W-1:0] rowCache_address_sram,
    input  logic [ADDR_W-1:0] output_address_sram,
    output logic [ADDR_W-1:0] sram_address,
    output logic [ADDR_W-1:0] sdram_address,
    output logic [LS_W-1:0]   line_sel,
    output logic              busy,
    output logic              rd_done,
    output logic              addr_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [WIDTH_W-1:0]   rc_col;
    logic [LS_W-1:0]      rc_line;
    logic [ADDR_W-1:0]    rc_base;
    logic [ADDR_W-1:0]    out_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic [ADDR_W-1:0]    wr_ptr;

    logic [WIDTH_W-1:0]   eff_w;
    logic [ADDR_W-1:0]    width_ext;
    logic [ADDR_W-1:0]    out_len;
    logic [ADDR_W-1:0]    out_last;

    // A zero width behaves as width 1; a width not exceeding the trim
    // still yields a one-entry output region.
    always_comb begin
        eff_w     = (image_width == '0) ? WIDTH_W'(1) : image_width;
        width_ext = ADDR_W'(image_width);
        out_len   = (width_ext > ADDR_W'(OUT_TRIM)) ? width_ext - ADDR_W'(OUT_TRIM)
                                                    : ADDR_W'(1);
        out_last  = output_address_sram + out_len - ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!n_rst || start_flag) begin
            rc_col  <= '0;
            rc_line <= '0;
            rc_base <= rowCache_address_sram;
            out_ptr <= output_address_sram;
            rd_ptr  <= start_address_sdram;
            wr_ptr  <= dest_address_sdram;
            rd_done <= 1'b0;
            state   <= n_rst ? RUN : IDLE;
        end else begin
            if (state != IDLE && sram_update) begin
                if (sram_mode) begin
                    // Line bases advance by repeated addition of the width.
                    if (rc_col == eff_w - WIDTH_W'(1)) begin
                        rc_col <= '0;
                        if (rc_line == LS_W'(NUM_LINES - 1)) begin
                            rc_line <= '0;
                            rc_base <= rowCache_address_sram;
                        end else begin
                            rc_line <= rc_line + LS_W'(1);
                            rc_base <= rc_base + ADDR_W'(eff_w);
                        end
                    end else begin
                        rc_col <= rc_col + WIDTH_W'(1);
                    end
                end else begin
                    out_ptr <= (out_ptr == out_last) ? output_address_sram
                                                     : out_ptr + ADDR_W'(1);
                end
            end
            if (sdram_update) begin
                if (sdram_mode) begin
                    if (state == RUN) begin
                        if (rd_ptr == finish_address_sdram) begin
                            rd_done <= 1'b1;
                            state   <= DONE;
                        end else begin
                            rd_ptr <= rd_ptr + ADDR_W'(1);
                        end
                    end
                end else if (state != IDLE) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
            end
        end
    end

`ifdef ADDR_GEN_ERR_CHECK_EN
    logic err_evt;

    always_comb begin
        err_evt = ((state == IDLE) && (sram_update || sdram_update))
               || (sdram_update && sdram_mode && (state == DONE))
               || (sdram_update && (wr_ptr == '1));
    end

    always_ff @(posedge clk) begin
        if (!n_rst || start_flag) begin
            addr_err <= 1'b0;
        end else if (err_evt) begin
            addr_err <= 1'b1;
        end
    end
`else
    assign addr_err = 1'b0;
`endif

    assign sram_address  = sram_mode  ? rc_base + ADDR_W'(rc_col) : out_ptr;
    assign sdram_address = sdram_mode ? rd_ptr : wr_ptr;
    assign line_sel      = rc_line;
    assign busy          = (state == RUN);

endmodule

// File: tb/tb_sram_sdram_address_gen.sv
module tb_sram_sdram_address_gen;

    localparam int AW = 26;
    localparam int WW = 13;
    localparam int NL = 3;
    localparam int OT = 1;
`ifdef ADDR_GEN_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk;
    logic          n_rst;
    logic          start_flag;
    logic          sram_mode;
    logic          sdram_mode;
    logic          sram_update;
    logic          sdram_update;
    logic [WW-1:0] image_width;
    logic [AW-1:0] start_address_sdram;
    logic [AW-1:0] finish_address_sdram;
    logic [AW-1:0] dest_address_sdram;
    logic [AW-1:0] rowCache_address_sram;
    logic [AW-1:0] output_address_sram;
    logic [AW-1:0] sram_address;
    logic [AW-1:0] sdram_address;
    logic [1:0]    line_sel;
    logic          busy;
    logic          rd_done;
    logic          addr_err;

    sram_sdram_address_gen #(
        .ADDR_W(AW), .WIDTH_W(WW), .NUM_LINES(NL), .OUT_TRIM(OT)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start_flag(start_flag),
        .sram_mode(sram_mode), .sdram_mode(sdram_mode),
        .sram_update(sram_update), .sdram_update(sdram_update),
        .image_width(image_width),
        .start_address_sdram(start_address_sdram),
        .finish_address_sdram(finish_address_sdram),
        .dest_address_sdram(dest_address_sdram),
        .rowCache_address_sram(rowCache_address_sram),
        .output_address_sram(output_address_sram),
        .sram_address(sram_address), .sdram_address(sdram_address),
        .line_sel(line_sel), .busy(busy), .rd_done(rd_done),
        .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock edge; pulses are dropped right after it is sampled.
    task automatic tick();
        @(posedge clk);
        #1;
        start_flag   = 1'b0;
        sram_update  = 1'b0;
        sdram_update = 1'b0;
        n_rst        = 1'b1;
        #1;
    endtask

    typedef struct {
        bit st, su, du, sm, dm;
        int unsigned sram, sdram;
        bit busy, done, err;
    } vec_t;

    vec_t tbl[12];

    // Reference model: pointers expressed as counts of accepted advances.
    bit            m_active, m_done, m_err;
    int unsigned   rc_n, out_n;
    logic [AW-1:0] rd_n, wr_n;

    task automatic model_clear(input bit act);
        m_active = act; m_done = 1'b0; m_err = 1'b0;
        rc_n = 0; out_n = 0; rd_n = '0; wr_n = '0;
    endtask

    function automatic int unsigned eff_width();
        return (image_width == 0) ? 1 : int'(image_width);
    endfunction

    function automatic int unsigned out_length();
        return (int'(image_width) > OT) ? int'(image_width) - OT : 1;
    endfunction

    task automatic model_step(input bit rst, input bit st, input bit su, input bit du,
                              input bit sm, input bit dm);
        logic [AW-1:0] wr_cur, rd_cur;
        wr_cur = dest_address_sdram + wr_n;
        rd_cur = start_address_sdram + rd_n;
        if (rst) model_clear(1'b0);
        else if (st) model_clear(1'b1);
        else if (m_active) begin
            if (su) begin
                if (sm) rc_n = (rc_n + 1) % (eff_width() * NL);
                else    out_n = (out_n + 1) % out_length();
            end
            if (du) begin
                if (wr_cur == '1) m_err = 1'b1;
                if (dm) begin
                    if (m_done) m_err = 1'b1;
                    else if (rd_cur == finish_address_sdram) m_done = 1'b1;
                    else rd_n = rd_n + 1'b1;
                end else begin
                    wr_n = wr_n + 1'b1;
                end
            end
        end else if (su || du) begin
            m_err = 1'b1;
        end
    endtask

    task automatic model_check();
        logic [AW-1:0] e_sram, e_sdram;
        e_sram  = sram_mode ? rowCache_address_sram + AW'(rc_n)
                            : output_address_sram + AW'(out_n);
        e_sdram = sdram_mode ? start_address_sdram + rd_n : dest_address_sdram + wr_n;
        check("rnd_sram", 32'(sram_address), 32'(e_sram));
        check("rnd_sdram", 32'(sdram_address), 32'(e_sdram));
        check("rnd_line", 32'(line_sel), rc_n / eff_width());
        check("rnd_busy", 32'(busy), 32'(m_active && !m_done));
        check("rnd_done", 32'(rd_done), 32'(m_done));
        check("rnd_err", 32'(addr_err), 32'(m_err && ERR_EN));
    endtask

    initial begin
        n_rst = 1'b0; start_flag = 1'b0; sram_mode = 1'b1; sdram_mode = 1'b1;
        sram_update = 1'b0; sdram_update = 1'b0;
        image_width = 13'd30;
        rowCache_address_sram = '0;
        output_address_sram   = 26'd42;
        start_address_sdram   = 26'd300;
        finish_address_sdram  = 26'd305;
        dest_address_sdram    = 26'd5000;

        // Reset values
        repeat (10) @(posedge clk);
        #1;
        sram_mode = 1'b1; #1; check("rst_sram_rc", 32'(sram_address), 0);
        sram_mode = 1'b0; #1; check("rst_sram_out", 32'(sram_address), 42);
        sdram_mode = 1'b1; #1; check("rst_sdram_rd", 32'(sdram_address), 300);
        sdram_mode = 1'b0; #1; check("rst_sdram_wr", 32'(sdram_address), 5000);
        check("rst_busy", 32'(busy), 0);
        check("rst_line", 32'(line_sel), 0);
        check("rst_done", 32'(rd_done), 0);
        check("rst_err", 32'(addr_err), 0);
        n_rst = 1'b1;

        // Row-cache ring, width 30, three lines
        start_flag = 1'b1; tick();
        sram_mode = 1'b1; #1;
        check("start_busy", 32'(busy), 1);
        for (int k = 1; k <= 95; k++) begin
            sram_update = 1'b1; tick();
            check("ring_addr", 32'(sram_address), 32'(k % 90));
            check("ring_line", 32'(line_sel), 32'((k / 30) % 3));
        end

        // Output region wrap: 29 entries from 42
        sram_mode = 1'b0; #1;
        for (int k = 1; k <= 34; k++) begin
            sram_update = 1'b1; tick();
            check("out_addr", 32'(sram_address), 32'(42 + k % 29));
        end

        // Read end, DONE behaviour, concurrency, error flag
        tbl[0]  = '{1, 1, 0, 1, 1, 0, 300,  1, 0, 0};
        tbl[1]  = '{0, 1, 1, 1, 1, 1, 301,  1, 0, 0};
        tbl[2]  = '{0, 0, 1, 1, 1, 1, 302,  1, 0, 0};
        tbl[3]  = '{0, 0, 1, 1, 1, 1, 303,  1, 0, 0};
        tbl[4]  = '{0, 0, 1, 1, 1, 1, 304,  1, 0, 0};
        tbl[5]  = '{0, 0, 1, 1, 1, 1, 305,  1, 0, 0};
        tbl[6]  = '{0, 0, 1, 1, 1, 1, 305,  0, 1, 0};
        tbl[7]  = '{0, 0, 1, 0, 0, 42, 5001, 0, 1, 0};
        tbl[8]  = '{0, 0, 1, 1, 1, 1, 305,  0, 1, 1};
        tbl[9]  = '{0, 1, 0, 1, 1, 2, 305,  0, 1, 1};
        tbl[10] = '{1, 0, 0, 1, 0, 0, 5000, 1, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 1, 42, 300, 1, 0, 0};
        for (int i = 0; i < 12; i++) begin
            start_flag = tbl[i].st; sram_update = tbl[i].su; sdram_update = tbl[i].du;
            sram_mode = tbl[i].sm; sdram_mode = tbl[i].dm;
            tick();
            check($sformatf("tbl%0d_sram", i), 32'(sram_address), tbl[i].sram);
            check($sformatf("tbl%0d_sdram", i), 32'(sdram_address), tbl[i].sdram);
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("tbl%0d_done", i), 32'(rd_done), 32'(tbl[i].done));
            check($sformatf("tbl%0d_err", i), 32'(addr_err), 32'(tbl[i].err && ERR_EN));
        end

        // Randomized segments against the model
        for (int seg = 0; seg < 10; seg++) begin
            image_width           = WW'($urandom_range(0, 6));
            rowCache_address_sram = AW'($urandom);
            output_address_sram   = AW'($urandom);
            start_address_sdram   = AW'($urandom_range(0, 100000));
            finish_address_sdram  = start_address_sdram + AW'($urandom_range(0, 8));
            dest_address_sdram    = ($urandom_range(0, 1) == 1) ? 26'h3FF_FFFD : AW'($urandom);
            n_rst = 1'b0;
            tick();
            model_clear(1'b0);
            for (int c = 0; c < 60; c++) begin
                bit r_rst, r_st, r_su, r_du, r_sm, r_dm;
                r_rst = ($urandom_range(0, 39) == 0);
                r_st  = (c == 3) || ($urandom_range(0, 11) == 0);
                r_su  = $urandom_range(0, 1) == 1;
                r_du  = $urandom_range(0, 1) == 1;
                r_sm  = $urandom_range(0, 1) == 1;
                r_dm  = $urandom_range(0, 1) == 1;
                n_rst = !r_rst; start_flag = r_st;
                sram_update = r_su; sdram_update = r_du;
                sram_mode = r_sm; sdram_mode = r_dm;
                tick();
                model_step(r_rst, r_st, r_su, r_du, r_sm, r_dm);
                model_check();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
